boot_loader_ctrl: RTL and testbench
===================================

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 SHALL have parameter BOOT_LEN, default 276; number of bytes copied (range 1..65536).
REQ-002 SHALL have parameter MEM_BASE, default 16'h0000; first destination address.
REQ-003 SHALL have parameter EXEC_ADDR, default 16'h0000; value driven on execute_addr.
REQ-004 SHALL have port clk_sys  in  1  system clock (32 MHz); all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a copy.
REQ-007 SHALL have port abort  in  1  synchronous cancel of a copy in progress.
REQ-008 SHALL have port rom_addr  out  16  boot ROM read address.
REQ-009 SHALL have port rom_data  in  8  boot ROM data, valid 1 cycle after rom_addr changes.
REQ-010 SHALL have port mem_addr  out  16  destination write address.
REQ-011 SHALL have port mem_data  out  8  destination write data.
REQ-012 SHALL have port mem_wr  out  1  write request.
REQ-013 SHALL have port mem_wait  in  1  sink stall; a write is accepted on an edge where mem_wr=1 and mem_wait=0.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port execute_enable  out  1  one-cycle completion pulse.
REQ-016 SHALL have port execute_addr  out  16  constant EXEC_ADDR.
REQ-017 SHALL have port checksum  out  8  modulo-256 sum of copied bytes.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, WRITE and DONE, plus a 16-bit byte index idx.
REQ-019 IDLE: on start=1 and abort=0, SHALL clear idx and the checksum accumulator and go to FETCH; otherwise SHALL stay in IDLE.
REQ-020 FETCH: SHALL drive rom_addr=idx for exactly one cycle, then go to WRITE, latching rom_data into mem_data on that edge.
REQ-021 WRITE: SHALL hold mem_wr=1, mem_addr=(MEM_BASE+idx) mod 2^16 and mem_data stable while mem_wait=1.
REQ-022 WRITE, on acceptance: if idx=BOOT_LEN-1, SHALL go to DONE; else SHALL set idx=idx+1 and go to FETCH.
REQ-023 DONE: SHALL assert execute_enable for exactly one cycle, then go to IDLE.
REQ-024 With mem_wait=0 throughout and start sampled at edge 0: byte k SHALL be accepted at edge 2k+2, and execute_enable SHALL be high in the cycle after edge 2*BOOT_LEN.
REQ-025 start while busy=1 SHALL be ignored; no restart and no queuing.
REQ-026 abort=1 in FETCH or WRITE SHALL go to IDLE at the next edge, deassert mem_wr, and suppress execute_enable; a write accepted on that same edge still counts.
REQ-027 abort=1 together with start=1 in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-028 mem_wr SHALL be 1 only in WRITE; rom_addr SHALL hold its last value outside FETCH.

Reset
REQ-029 reset_n=0 SHALL immediately force state=IDLE, idx=0, rom_addr=0, mem_addr=MEM_BASE, mem_data=0, mem_wr=0, busy=0, execute_enable=0, checksum=0.
REQ-030 Reset asserted mid-copy SHALL abandon the copy without completing the pending write; the FSM SHALL remain in IDLE after release until a new start.

Configuration
REQ-031 With BOOT_CHECKSUM_EN defined: checksum SHALL add each accepted byte mod 256, and SHALL be stable from DONE until the next start or reset.
REQ-032 With BOOT_CHECKSUM_EN undefined: checksum SHALL be constant 8'h00, with no accumulator logic present.

Verification
REQ-033 BOOT_LEN=276, mem_wait=0, start pulse -> 276 writes to 0x0000..0x0113 matching ROM; execute_enable is a single pulse after edge 552; busy then falls.
REQ-034 BOOT_LEN=4, ROM=01,02,03,FF, BOOT_CHECKSUM_EN defined -> checksum=8'h05 at DONE; with the macro undefined -> 8'h00.
REQ-035 mem_wait held high 3 cycles on byte 2 -> mem_wr, mem_addr and mem_data stable for 4 cycles; completion delayed exactly 3 cycles.
REQ-036 abort on the WRITE cycle of byte 10 (mem_wait=1) -> exactly 10 writes, no execute_enable, busy=0 next cycle; start and abort together in IDLE -> no activity.
REQ-037 reset_n pulsed low mid-copy -> all outputs at reset values immediately; a start pulse after release re-copies from idx 0.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl
// Copies BOOT_LEN bytes from a boot ROM into a destination memory, one byte
// every two cycles when the sink does not stall. When the copy finishes, it
// pulses execute_enable so the CPU can jump to EXEC_ADDR.
//
// Optional feature: define BOOT_CHECKSUM_EN to build the running modulo-256
// checksum of the accepted bytes. When it is undefined, checksum is tied to 0.
//
// Ports
//   clk_sys         system clock; all logic uses its rising edge
//   reset_n         asynchronous, active-low reset
//   start           one-cycle request to begin a copy (ignored while busy)
//   abort           synchronous cancel of a copy in progress
//   rom_addr/data   boot ROM read port; data is sampled one cycle after addr
//   mem_addr/data   destination write address and data
//   mem_wr          write request; a write is accepted when mem_wait is low
//   mem_wait        sink stall
//   busy            high whenever the FSM is not idle
//   execute_enable  one-cycle completion pulse
//   execute_addr    constant EXEC_ADDR
//   checksum        modulo-256 sum of the copied bytes
module boot_loader_ctrl #(
  parameter int          BOOT_LEN  = 276,
  parameter logic [15:0] MEM_BASE  = 16'h0000,
  parameter logic [15:0] EXEC_ADDR = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  input  logic        mem_wait,
  output logic        busy,
  output logic        execute_enable,
  output logic [15:0] execute_addr,
  output logic [7:0]  checksum
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  // Index of the final byte. BOOT_LEN = 65536 maps to 16'hFFFF.
  localparam logic [15:0] LAST_IDX = 16'(BOOT_LEN - 1);

  state_t      state_reg, state_next;
  logic [15:0] idx_reg, idx_next;
  logic [15:0] rom_addr_reg, rom_addr_next;
  logic [7:0]  mem_data_reg, mem_data_next;
  logic        accept;
  logic        start_ok;

  assign accept   = (state_reg == WRITE) && !mem_wait;
  assign start_ok = (state_reg == IDLE) && start && !abort;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      idx_reg      <= 16'h0000;
      rom_addr_reg <= 16'h0000;
      mem_data_reg <= 8'h00;
    end else begin
      idx_reg      <= idx_next;
      rom_addr_reg <= rom_addr_next;
      mem_data_reg <= mem_data_next;
    end
  end

  // rom_addr is loaded on the edge that enters FETCH. The ROM answer is then
  // valid by the following edge, when it is latched into mem_data.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    rom_addr_next = rom_addr_reg;
    mem_data_next = mem_data_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next    = FETCH;
          idx_next      = 16'h0000;
          rom_addr_next = 16'h0000;
        end
      end
      FETCH: begin
        mem_data_next = rom_data;
        state_next    = abort ? IDLE : WRITE;
      end
      WRITE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (accept) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next      = idx_reg + 16'd1;
            rom_addr_next = idx_reg + 16'd1;
            state_next    = FETCH;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rom_addr       = rom_addr_reg;
  assign mem_addr       = MEM_BASE + idx_reg;
  assign mem_data       = mem_data_reg;
  assign mem_wr         = (state_reg == WRITE);
  assign busy           = (state_reg != IDLE);
  assign execute_enable = (state_reg == DONE);
  assign execute_addr   = EXEC_ADDR;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum_reg, csum_next;

  // A write that is accepted on the same edge as an abort still counts.
  always_comb begin
    csum_next = csum_reg;
    if (start_ok) begin
      csum_next = 8'h00;
    end else if (accept) begin
      csum_next = csum_reg + mem_data_reg;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      csum_reg <= 8'h00;
    end else begin
      csum_reg <= csum_next;
    end
  end

  assign checksum = csum_reg;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Testbench for boot_loader_ctrl.
// It uses two instances. dut has the default parameters and covers the full
// copy, stalls, abort and reset. dut_s has BOOT_LEN=4 and a wrapping MEM_BASE,
// and covers the checksum and address wrap-around.
`timescale 1ns/1ps
module tb_boot_loader_ctrl;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        start, abort, mem_wait;
  logic [15:0] rom_addr, mem_addr, execute_addr;
  logic [7:0]  rom_data, mem_data, checksum;
  logic        mem_wr, busy, execute_enable;

  logic        start_s;
  logic        abort_s = 1'b0;
  logic        mem_wait_s = 1'b0;
  logic [15:0] rom_addr_s, mem_addr_s, execute_addr_s;
  logic [7:0]  rom_data_s, mem_data_s, checksum_s;
  logic        mem_wr_s, busy_s, execute_enable_s;

  always #15 clk_sys = ~clk_sys;

  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return (a[7:0] * 8'd13) ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] rom_small(input logic [15:0] a);
    case (a)
      16'd0:   return 8'h01;
      16'd1:   return 8'h02;
      16'd2:   return 8'h03;
      16'd3:   return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  assign rom_data   = rom_f(rom_addr);
  assign rom_data_s = rom_small(rom_addr_s);

  boot_loader_ctrl dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_wr(mem_wr), .mem_wait(mem_wait), .busy(busy),
    .execute_enable(execute_enable), .execute_addr(execute_addr),
    .checksum(checksum)
  );

  boot_loader_ctrl #(.BOOT_LEN(4), .MEM_BASE(16'hFFFE), .EXEC_ADDR(16'hA55A)) dut_s (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start_s), .abort(abort_s),
    .rom_addr(rom_addr_s), .rom_data(rom_data_s), .mem_addr(mem_addr_s),
    .mem_data(mem_data_s), .mem_wr(mem_wr_s), .mem_wait(mem_wait_s), .busy(busy_s),
    .execute_enable(execute_enable_s), .execute_addr(execute_addr_s),
    .checksum(checksum_s)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  int  cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Scoreboards: expected writes are queued when a copy is started and are
  // popped when an accepted write is observed.
  wr_t q[$];
  wr_t q_s[$];
  wr_t e, e_s;
  int  wr_count = 0, exec_count = 0, exec_cyc = 0;
  int  wr_count_s = 0, exec_count_s = 0, exec_cyc_s = 0;

  always @(negedge clk_sys) begin
    if (mem_wr && !mem_wait) begin
      wr_count++;
      if (q.size() == 0) begin
        check("extra_write", {16'h0, mem_addr}, 32'hDEAD0000);
      end else begin
        e = q.pop_front();
        check("wr_addr", {16'h0, mem_addr}, {16'h0, e.addr});
        check("wr_data", {24'h0, mem_data}, {24'h0, e.data});
      end
    end
    if (execute_enable) begin
      exec_count++;
      exec_cyc = cyc;
    end
    if (mem_wr_s && !mem_wait_s) begin
      wr_count_s++;
      if (q_s.size() == 0) begin
        check("extra_write_s", {16'h0, mem_addr_s}, 32'hDEAD0000);
      end else begin
        e_s = q_s.pop_front();
        check("wr_addr_s", {16'h0, mem_addr_s}, {16'h0, e_s.addr});
        check("wr_data_s", {24'h0, mem_data_s}, {24'h0, e_s.data});
      end
    end
    if (execute_enable_s) begin
      exec_count_s++;
      exec_cyc_s = cyc;
    end
  end

  task automatic push_big();
    q.delete();
    for (int i = 0; i < 276; i++) q.push_back('{addr: 16'(i), data: rom_f(16'(i))});
    wr_count   = 0;
    exec_count = 0;
  endtask

  // Raises start for one cycle. s is the cycle count just before the edge
  // that samples start.
  task automatic pulse_start(output int s);
    @(posedge clk_sys); #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk_sys); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check({tag, "_idle_timeout"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"}, {16'h0, rom_addr}, 32'h0);
    check({tag, "_mem_addr"}, {16'h0, mem_addr}, 32'h0);
    check({tag, "_mem_data"}, {24'h0, mem_data}, 32'h0);
    check({tag, "_mem_wr"},   {31'h0, mem_wr}, 32'h0);
    check({tag, "_busy"},     {31'h0, busy}, 32'h0);
    check({tag, "_exec_en"},  {31'h0, execute_enable}, 32'h0);
    check({tag, "_checksum"}, {24'h0, checksum}, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, n, wc;
    logic [15:0] a_hold;
    logic [7:0]  d_hold;
    logic [7:0]  exp_sum;
    logic [7:0]  exp_sum_s;

    exp_sum   = 8'h00;
    exp_sum_s = 8'h00;
`ifdef BOOT_CHECKSUM_EN
    for (int i = 0; i < 276; i++) exp_sum = exp_sum + rom_f(16'(i));
    exp_sum_s = 8'h05;
`endif

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; mem_wait = 1'b0; start_s = 1'b0;
    repeat (2) @(posedge clk_sys); #1;
    check_reset_outputs("rst");
    check("rst_exec_addr", {16'h0, execute_addr}, 32'h0);
    check("rst_mem_addr_s", {16'h0, mem_addr_s}, 32'hFFFE);
    check("rst_exec_addr_s", {16'h0, execute_addr_s}, 32'hA55A);
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys); #1;
    check("idle_after_rst", {31'h0, busy}, 32'h0);

    // A: full copy with no stalls; a second start mid-copy must be ignored.
    push_big();
    pulse_start(s);
    repeat (100) @(posedge clk_sys); #1;
    start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    wait_idle("A", 2000);
    check("A_writes", wr_count, 276);
    check("A_exec_count", exec_count, 1);
    check("A_exec_cycle", exec_cyc, s + 553);
    check("A_busy_fall", cyc, exec_cyc + 1);
    check("A_queue_left", q.size(), 0);
    check("A_checksum", {24'h0, checksum}, {24'h0, exp_sum});
    repeat (5) @(posedge clk_sys); #1;
    check("A_checksum_hold", {24'h0, checksum}, {24'h0, exp_sum});
    $display("copy A: writes=%0d exec_pulses=%0d exec_cycle=%0d", wr_count, exec_count, exec_cyc - s);

    // B: mem_wait held high for 3 cycles on byte 2.
    push_big();
    pulse_start(s);
    n = 0;
    while (!(mem_wr && mem_addr == 16'd2) && n < 20) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("B_reach_byte2", {15'h0, mem_wr, mem_addr}, {15'h0, 1'b1, 16'd2});
    mem_wait = 1'b1;
    a_hold = mem_addr;
    d_hold = mem_data;
    check("B_data_byte2", {24'h0, d_hold}, {24'h0, rom_f(16'd2)});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_sys); #1;
      if (i == 2) mem_wait = 1'b0;
      check("B_stall_wr", {31'h0, mem_wr}, 32'h1);
      check("B_stall_addr", {16'h0, mem_addr}, {16'h0, a_hold});
      check("B_stall_data", {24'h0, mem_data}, {24'h0, d_hold});
    end
    wait_idle("B", 2000);
    check("B_writes", wr_count, 276);
    check("B_exec_count", exec_count, 1);
    check("B_exec_cycle", exec_cyc, s + 556);
    check("B_queue_left", q.size(), 0);
    $display("copy B: writes=%0d exec_pulses=%0d exec_cycle=%0d", wr_count, exec_count, exec_cyc - s);

    // C: abort on the WRITE cycle of byte 10 while the sink stalls.
    push_big();
    pulse_start(s);
    n = 0;
    while (!(mem_wr && mem_addr == 16'd10) && n < 40) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("C_reach_byte10", {15'h0, mem_wr, mem_addr}, {15'h0, 1'b1, 16'd10});
    mem_wait = 1'b1;
    abort = 1'b1;
    @(posedge clk_sys); #1;
    abort = 1'b0;
    mem_wait = 1'b0;
    check("C_busy_after_abort", {31'h0, busy}, 32'h0);
    check("C_wr_after_abort", {31'h0, mem_wr}, 32'h0);
    repeat (10) @(posedge clk_sys); #1;
    check("C_writes", wr_count, 10);
    check("C_exec_count", exec_count, 0);
    check("C_queue_left", q.size(), 266);
    $display("copy C (aborted): writes=%0d exec_pulses=%0d", wr_count, exec_count);
    q.delete();

    // D: start and abort together in IDLE; abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    abort = 1'b0;
    check("D_busy", {31'h0, busy}, 32'h0);
    repeat (5) @(posedge clk_sys); #1;
    check("D_busy_later", {31'h0, busy}, 32'h0);
    check("D_writes", wr_count, 10);
    $display("copy D (start+abort): writes=%0d", wr_count);

    // E: reset mid-copy, then restart from byte 0.
    push_big();
    pulse_start(s);
    repeat (50) @(posedge clk_sys); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("E_rst");
    wc = wr_count;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk_sys); #1;
    check("E_idle_after_rel", {31'h0, busy}, 32'h0);
    check("E_no_writes", wr_count, wc);
    $display("copy E (reset): writes_before_reset=%0d", wc);
    push_big();
    pulse_start(s);
    wait_idle("E2", 2000);
    check("E2_writes", wr_count, 276);
    check("E2_exec_count", exec_count, 1);
    check("E2_queue_left", q.size(), 0);
    check("E2_checksum", {24'h0, checksum}, {24'h0, exp_sum});
    $display("copy E2: writes=%0d exec_pulses=%0d", wr_count, exec_count);

    // F: four-byte copy on the small instance, which tests the checksum and
    // the destination address wrap.
    q_s.delete();
    q_s.push_back('{addr: 16'hFFFE, data: 8'h01});
    q_s.push_back('{addr: 16'hFFFF, data: 8'h02});
    q_s.push_back('{addr: 16'h0000, data: 8'h03});
    q_s.push_back('{addr: 16'h0001, data: 8'hFF});
    @(posedge clk_sys); #1;
    start_s = 1'b1;
    s = cyc;
    @(posedge clk_sys); #1;
    start_s = 1'b0;
    n = 0;
    while (busy_s && n < 50) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("F_idle_timeout", {31'h0, busy_s}, 32'h0);
    check("F_writes", wr_count_s, 4);
    check("F_exec_count", exec_count_s, 1);
    check("F_exec_cycle", exec_cyc_s, s + 9);
    check("F_queue_left", q_s.size(), 0);
    check("F_checksum", {24'h0, checksum_s}, {24'h0, exp_sum_s});
    $display("copy F (small): writes=%0d exec_pulses=%0d checksum=%02h", wr_count_s, exec_count_s, checksum_s);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
